mem_sram_responder: RTL
=======================

# mem_sram_responder

- Responder end of the CPU memory bus (mem_cmd_*/mem_rsp_*).
- Accepts single-beat read/write commands and executes them on an external asynchronous 32-bit SRAM with programmable wait states.
- Returns exactly one read response per accepted read; writes complete silently.
- Sits between the bus initiator and the board SRAM pins; address decode happens upstream, so every command presented here targets the SRAM.

## Interface
Parameters:
- ADDR_BITS, 19, SRAM word-address width; byte address bits [ADDR_BITS+1:2] are used.
- RD_CYCLES, 2, cycles OE is asserted before read data is sampled (>=1).
- WR_CYCLES, 2, cycles WE is asserted low (>=1).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_cmd_valid  in  1  command present.
- mem_cmd_ready  out  1  command accepted when valid&&ready.
- mem_cmd_instr  in  1  instruction fetch flag; no functional effect.
- mem_cmd_wr  in  1  1=write, 0=read.
- mem_cmd_addr  in  32  byte address.
- mem_cmd_wdata  in  32  write data.
- mem_cmd_be  in  4  byte enables; 0 on fetches.
- mem_rsp_ready  out  1  one-cycle read-response strobe.
- mem_rsp_rdata  out  32  read data, valid with mem_rsp_ready, held until next response.
- sram_addr  out  ADDR_BITS  word address.
- sram_wdata  out  32  data to SRAM.
- sram_data_oe  out  1  tristate enable for sram_wdata.
- sram_rdata  in  32  data from SRAM.
- sram_ce_  out  1  chip enable, active low.
- sram_oe_  out  1  output enable, active low.
- sram_we_  out  1  write enable, active low.
- sram_be_  out  4  byte lanes, active low.

## Operation
States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: mem_cmd_ready=1 (combinational from state). All SRAM strobes high, sram_data_oe=0.
- On accept, register addr[ADDR_BITS+1:2], wdata and be. addr[1:0] and bits above ADDR_BITS+1 are ignored (aliasing).
- Read (wr=0): go to READ for RD_CYCLES cycles with ce_=0, oe_=0 and sram_be_=0000; be is ignored, so reads are always full-word. Sample sram_rdata into mem_rsp_rdata on the last READ cycle, then return to IDLE with mem_rsp_ready=1 for that one cycle.
- Write (wr=1, be!=0):
  - WR_SETUP, 1 cycle: ce_=0, we_=1, data_oe=1.
  - WR_PULSE, WR_CYCLES cycles: we_=0, sram_be_=~be.
  - WR_HOLD, 1 cycle: we_=1, data_oe=1, sram_be_ still =~be.
  - Then IDLE. No response is generated.
- Write with be=0000: accepted, no SRAM cycle, stays IDLE, no response.
- oe_ and we_ are never low in the same cycle. data_oe is never 1 while oe_=0.
- A wait counter of width clog2(max(RD_CYCLES,WR_CYCLES)+1) loads on state entry and advances on zero.

## Timing
- Reset values: mem_cmd_ready=0 during reset, 1 in the cycle after; mem_rsp_ready=0; mem_rsp_rdata=0; sram_addr=0; sram_wdata=0; sram_data_oe=0; sram_ce_=1; sram_oe_=1; sram_we_=1; sram_be_=1111; state=IDLE.
- Reset mid-access abandons the access: no response is emitted and strobes deassert in the next cycle.
- Read accepted in cycle T: READ occupies T+1..T+RD_CYCLES, and mem_rsp_ready=1 in T+RD_CYCLES+1. Latency is RD_CYCLES+1, which is 3 at default.
- The response cycle is IDLE, so mem_cmd_ready=1 there. A new command may be accepted in the same cycle as the previous read response, giving back-to-back reads with one read every RD_CYCLES+1 cycles.
- Write accepted in T: busy T+1..T+WR_CYCLES+2, and mem_cmd_ready=1 again at T+WR_CYCLES+3.
- At most one command is outstanding; mem_cmd_ready=0 in every non-IDLE state.
- mem_cmd_* inputs are sampled only on the accept edge; later changes are ignored.

## Test plan
- Reset: assert reset for 3 cycles during a READ -> mem_rsp_ready never pulses; cycle after release shows ce_=oe_=we_=1, be_=1111, mem_cmd_ready=1.
- Word write then read at addr 0x0000_0010 (wdata 0xDEADBEEF, be 1111) -> sram_addr=4; we_ low for exactly 2 cycles; read returns 0xDEADBEEF with mem_rsp_ready exactly 3 cycles after accept.
- Byte write be=0100, wdata 0x00AB0000 over 0x11223344 at addr 0x20 -> sram_be_=1011 during WR_PULSE; readback 0x11AB3344.
- Back-to-back fetches (instr=1, be=0000) at 0x0, 0x4, 0x8 with valid held high -> each accepted in the same cycle as the previous response; responses every 3 cycles with correct data.
- Write with be=0000 -> no ce_/we_ activity; mem_cmd_ready stays 1; no response.
- Aliasing with ADDR_BITS=19: read of 0x0200_0004 -> sram_addr=1, same data as address 0x4.

Source files
------------

// File: rtl/mem_sram_responder.sv
// mem_sram_responder: single-beat command responder driving an
// asynchronous 32-bit SRAM with programmable read/write wait states.
module mem_sram_responder #(
    parameter int ADDR_BITS = 19,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_cmd_valid,
    output logic                 mem_cmd_ready,
    input  logic                 mem_cmd_instr,
    input  logic                 mem_cmd_wr,
    input  logic [31:0]          mem_cmd_addr,
    input  logic [31:0]          mem_cmd_wdata,
    input  logic [3:0]           mem_cmd_be,
    output logic                 mem_rsp_ready,
    output logic [31:0]          mem_rsp_rdata,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [31:0]          sram_wdata,
    output logic                 sram_data_oe,
    input  logic [31:0]          sram_rdata,
    output logic                 sram_ce_,
    output logic                 sram_oe_,
    output logic                 sram_we_,
    output logic [3:0]           sram_be_
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [3:0]            be_q;
    logic                  rsp_ready_q;
    logic [31:0]           rsp_rdata_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [31:0]           wdata_q;
    logic                  data_oe_q;
    logic                  ce_q;
    logic                  oe_q;
    logic                  we_q;
    logic [3:0]            sbe_q;

    // Byte offset, fetch flag and address bits above the SRAM alias away.
    logic unused_bits;
    assign unused_bits = ^{mem_cmd_instr, mem_cmd_addr[1:0],
                           mem_cmd_addr[31:ADDR_BITS+2]};

    // Ready only in IDLE and never while reset is held.
    assign mem_cmd_ready = (state_q == IDLE) && !reset;

    assign mem_rsp_ready = rsp_ready_q;
    assign mem_rsp_rdata = rsp_rdata_q;
    assign sram_addr     = addr_q;
    assign sram_wdata    = wdata_q;
    assign sram_data_oe  = data_oe_q;
    assign sram_ce_      = ce_q;
    assign sram_oe_      = oe_q;
    assign sram_we_      = we_q;
    assign sram_be_      = sbe_q;

    // Access sequencer: all SRAM strobes are registered outputs of this FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            be_q        <= '0;
            rsp_ready_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_oe_q   <= 1'b0;
            ce_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            sbe_q       <= 4'hF;
        end else begin
            rsp_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_cmd_valid) begin
                        addr_q  <= mem_cmd_addr[ADDR_BITS+1:2];
                        wdata_q <= mem_cmd_wdata;
                        be_q    <= mem_cmd_be;
                        if (!mem_cmd_wr) begin
                            state_q <= READ;
                            cnt_q   <= RD_LOAD;
                            ce_q    <= 1'b0;
                            oe_q    <= 1'b0;
                            sbe_q   <= 4'h0;
                        end else if (mem_cmd_be != 4'h0) begin
                            state_q   <= WR_SETUP;
                            ce_q      <= 1'b0;
                            data_oe_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt_q == '0) begin
                        state_q     <= IDLE;
                        rsp_rdata_q <= sram_rdata;
                        rsp_ready_q <= 1'b1;
                        ce_q        <= 1'b1;
                        oe_q        <= 1'b1;
                        sbe_q       <= 4'hF;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                    cnt_q   <= WR_LOAD;
                    we_q    <= 1'b0;
                    sbe_q   <= ~be_q;
                end
                WR_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= WR_HOLD;
                        we_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WR_HOLD: begin
                    state_q   <= IDLE;
                    ce_q      <= 1'b1;
                    data_oe_q <= 1'b0;
                    sbe_q     <= 4'hF;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
